// File: rtl/memory_pkg.sv
// Shared load/store definitions for the RISC-V data memory.
//   funct3_t     : load/store size and signedness code (RISC-V funct3).
//   load_extract : picks the byte/half/word out of a 32-bit word and extends it.
package LOAD_STORE_FNS;

    typedef enum logic [2:0] {
        BYTE   = 3'b000,
        HALF   = 3'b001,
        WORD   = 3'b010,
        BYTE_U = 3'b100,
        HALF_U = 3'b101
    } funct3_t;

    // Little-endian extraction. Unlisted codes return the full word.
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [1:0]  lane,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b100:  load_extract = {24'd0, b};
            3'b101:  load_extract = {16'd0, h};
            default: load_extract = w;
        endcase
    endfunction

endpackage

// File: rtl/memory_byte_en_ram.sv
// DEPTH x 32 RAM with a 4-bit byte-enable write port and a registered read.
//   clk, rst : clock, async active-high reset (clears the read register only)
//   i_we     : per-byte write enables
//   i_waddr  : write word index
//   i_wdata  : write data
//   i_raddr  : read word index
//   o_rdata  : read data, one cycle after i_raddr (old data on a same-address write)
module byte_en_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Storage is deliberately not reset so preloaded contents survive rst.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_rdata <= '0;
        else     o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/memory.sv
// Byte-addressed, word-organised data memory with one memory-mapped output register.
//   clk, rst              : clock, async active-high reset
//   addr, wren, wr_data   : core load/store port, size selected by funct3
//   funct3                : access size / signedness
//   rd_data               : load result, one cycle latency
//   outport               : memory-mapped output register at OUTPORT_ADDR
//   flash_en/addr/data    : full-word preload port, active even during reset
module memory
    import LOAD_STORE_FNS::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               DEPTH        = 256,
    parameter logic [WIDTH-1:0] OUTPORT_ADDR = 32'h0000_FFFC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] addr,
    input  logic             wren,
    input  logic [WIDTH-1:0] wr_data,
    input  funct3_t          funct3,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] outport,
    input  logic             flash_en,
    input  logic [WIDTH-1:0] flash_addr,
    input  logic [WIDTH-1:0] flash_data
);

    localparam int AW = $clog2(DEPTH);

    logic          w_hit;
    logic [3:0]    w_st_be;
    logic [31:0]   w_st_data;
    logic [3:0]    w_we;
    logic [AW-1:0] w_waddr;
    logic [31:0]   w_wdata;
    logic [31:0]   w_ram_q;
    logic          w_unused_flash;

    logic          r_rd_hit;
    logic [1:0]    r_rd_lane;
    logic [2:0]    r_rd_f3;
    logic [31:0]   r_port_snap;

    assign w_hit          = (addr[WIDTH-1:2] == OUTPORT_ADDR[WIDTH-1:2]);
    assign w_unused_flash = ^{flash_addr[1:0], flash_addr[WIDTH-1:AW+2]};

    // Store lanes: data is replicated so the enables alone pick the target bytes.
    always_comb begin
        w_st_be   = 4'b0000;
        w_st_data = wr_data;
        case (funct3)
            BYTE: begin
                w_st_be   = 4'b0001 << addr[1:0];
                w_st_data = {4{wr_data[7:0]}};
            end
            HALF: begin
                w_st_be   = addr[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{wr_data[15:0]}};
            end
            WORD:    w_st_be = 4'b1111;
            default: w_st_be = 4'b0000;
        endcase
    end

    // Single RAM write port: flash wins over a core store in the same cycle.
    always_comb begin
        w_we    = 4'b0000;
        w_waddr = addr[AW+1:2];
        w_wdata = w_st_data;
        if (flash_en) begin
            w_we    = 4'b1111;
            w_waddr = flash_addr[AW+1:2];
            w_wdata = flash_data;
        end else if (wren && !rst && !w_hit) begin
            w_we = w_st_be;
        end
    end

    byte_en_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (addr[AW+1:2]),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outport <= '0;
        end else if (wren && !flash_en && w_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_st_be[i]) outport[8*i +: 8] <= w_st_data[8*i +: 8];
            end
        end
    end

    // Load side: capture the select info alongside the RAM read so the
    // extraction below works on registered values only. The outport snapshot
    // gives read-before-write on an outport store too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_hit    <= 1'b0;
            r_rd_lane   <= 2'b00;
            r_rd_f3     <= 3'b000;
            r_port_snap <= '0;
        end else begin
            r_rd_hit    <= w_hit;
            r_rd_lane   <= addr[1:0];
            r_rd_f3     <= funct3;
            r_port_snap <= outport;
        end
    end

    assign rd_data = load_extract(r_rd_hit ? r_port_snap : w_ram_q, r_rd_lane, r_rd_f3);

endmodule

// File: tb/tb_memory.sv
module tb_memory;
    import LOAD_STORE_FNS::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wr_data, flash_addr, flash_data;
    logic        wren, flash_en;
    funct3_t     funct3;
    logic [31:0] rd_data, outport;

    int total = 0;
    int bad   = 0;

    memory dut (
        .clk(clk), .rst(rst), .addr(addr), .wren(wren), .wr_data(wr_data),
        .funct3(funct3), .rd_data(rd_data), .outport(outport),
        .flash_en(flash_en), .flash_addr(flash_addr), .flash_data(flash_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic [31:0] fa, fd;
        logic        we;
        logic [31:0] a, wd;
        logic [2:0]  f3;
        logic        ck;
        logic [31:0] erd, eout;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic fl, logic [31:0] fa, logic [31:0] fd,
                                logic we, logic [31:0] a, logic [31:0] wd,
                                logic [2:0] f3, logic ck, logic [31:0] erd,
                                logic [31:0] eout);
        vec_t v;
        v.fl = fl; v.fa = fa; v.fd = fd; v.we = we; v.a = a; v.wd = wd;
        v.f3 = f3; v.ck = ck; v.erd = erd; v.eout = eout;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle, sample 1 time unit after the rising edge.
    task automatic step(vec_t v, int idx);
        flash_en   = v.fl;
        flash_addr = v.fa;
        flash_data = v.fd;
        wren       = v.we;
        addr       = v.a;
        wr_data    = v.wd;
        funct3     = funct3_t'(v.f3);
        @(posedge clk);
        #1;
        if (v.ck) check($sformatf("vec%0d rd_data", idx), rd_data, v.erd);
        check($sformatf("vec%0d outport", idx), outport, v.eout);
        flash_en = 1'b0;
        wren     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wren = 1'b0; flash_en = 1'b0;
        addr = '0; wr_data = '0; flash_addr = '0; flash_data = '0; funct3 = WORD;
        #1;
        check("reset rd_data", rd_data, 32'h0);
        check("reset outport", outport, 32'h0);

        // Preload while held in reset.
        step(mk(1, 0,  32'd12345,    0, 0, 0, 3'b010, 1, 0, 0), 100);
        step(mk(1, 4,  32'd678910,   0, 0, 0, 3'b010, 1, 0, 0), 101);
        step(mk(1, 12, 32'hDEADBEEF, 0, 0, 0, 3'b010, 1, 0, 0), 102);
        rst = 1'b0;

        //         fl fa      fd            we a          wd            f3      ck erd           eout
        vq.push_back(mk(0, 0,      0,            0, 0,         0,            3'b010, 1, 32'd12345,    0));
        vq.push_back(mk(0, 0,      0,            0, 4,         0,            3'b010, 1, 32'd678910,   0));
        vq.push_back(mk(0, 0,      0,            0, 12,        0,            3'b010, 1, 32'hDEADBEEF, 0));
        vq.push_back(mk(0, 0,      0,            1, 8,         32'd101010,   3'b010, 0, 0,            0));
        vq.push_back(mk(0, 0,      0,            0, 8,         0,            3'b010, 1, 32'd101010,   0));
        vq.push_back(mk(0, 0,      0,            0, 4,         0,            3'b010, 1, 32'd678910,   0));
        vq.push_back(mk(0, 0,      0,            0, 12,        0,            3'b010, 1, 32'hDEADBEEF, 0));
        vq.push_back(mk(1, 16,     0,            0, 0,         0,            3'b010, 1, 32'd12345,    0));
        vq.push_back(mk(0, 0,      0,            1, 17,        32'h80,       3'b000, 1, 32'h0,        0));
        vq.push_back(mk(0, 0,      0,            0, 16,        0,            3'b010, 1, 32'h0000_8000, 0));
        vq.push_back(mk(0, 0,      0,            0, 17,        0,            3'b000, 1, 32'hFFFF_FF80, 0));
        vq.push_back(mk(0, 0,      0,            0, 17,        0,            3'b100, 1, 32'h0000_0080, 0));
        vq.push_back(mk(0, 0,      0,            1, 18,        32'hBEEF,     3'b001, 1, 32'h0,        0));
        vq.push_back(mk(0, 0,      0,            0, 18,        0,            3'b101, 1, 32'h0000_BEEF, 0));
        vq.push_back(mk(0, 0,      0,            0, 18,        0,            3'b001, 1, 32'hFFFF_BEEF, 0));
        vq.push_back(mk(0, 0,      0,            0, 16,        0,            3'b010, 1, 32'hBEEF_8000, 0));
        vq.push_back(mk(0, 0,      0,            0, 19,        0,            3'b000, 1, 32'hFFFF_FFBE, 0));
        vq.push_back(mk(0, 0,      0,            0, 16,        0,            3'b001, 1, 32'hFFFF_8000, 0));
        vq.push_back(mk(0, 0,      0,            0, 17,        0,            3'b101, 1, 32'h0000_8000, 0));
        vq.push_back(mk(0, 0,      0,            0, 16,        0,            3'b011, 1, 32'hBEEF_8000, 0));
        vq.push_back(mk(0, 0,      0,            1, 16,        32'hFFFF_FFFF, 3'b011, 1, 32'hBEEF_8000, 0));
        vq.push_back(mk(0, 0,      0,            0, 16,        0,            3'b010, 1, 32'hBEEF_8000, 0));
        // RAM word aliased by OUTPORT_ADDR (index 255 -> byte 0x3FC)
        vq.push_back(mk(1, 32'h3FC, 32'hA5A5_A5A5, 0, 0,        0,            3'b010, 0, 0,            0));
        vq.push_back(mk(0, 0,      0,            1, 32'hFFFC,  32'h1234_5678, 3'b010, 1, 32'h0,   32'h1234_5678));
        vq.push_back(mk(0, 0,      0,            0, 32'h3FC,   0,            3'b010, 1, 32'hA5A5_A5A5, 32'h1234_5678));
        vq.push_back(mk(0, 0,      0,            0, 32'hFFFC,  0,            3'b010, 1, 32'h1234_5678, 32'h1234_5678));
        vq.push_back(mk(0, 0,      0,            0, 32'hFFFD,  0,            3'b100, 1, 32'h0000_0056, 32'h1234_5678));
        vq.push_back(mk(0, 0,      0,            0, 32'hFFFE,  0,            3'b001, 1, 32'h0000_1234, 32'h1234_5678));
        vq.push_back(mk(0, 0,      0,            1, 32'hFFFF,  32'hEE,       3'b000, 0, 0,            32'hEE34_5678));
        vq.push_back(mk(0, 0,      0,            0, 32'hFFFF,  0,            3'b000, 1, 32'hFFFF_FFEE, 32'hEE34_5678));
        vq.push_back(mk(0, 0,      0,            0, 32'h404,   0,            3'b010, 1, 32'd678910,   32'hEE34_5678));
        // flash vs store collisions
        vq.push_back(mk(1, 0,      32'hCAFE_F00D, 1, 0,        32'h1111_1111, 3'b010, 1, 32'd12345,   32'hEE34_5678));
        vq.push_back(mk(0, 0,      0,            0, 0,         0,            3'b010, 1, 32'hCAFE_F00D, 32'hEE34_5678));
        vq.push_back(mk(1, 32'h20, 32'd7,        1, 32'hFFFC,  32'h0,        3'b010, 0, 0,            32'hEE34_5678));
        vq.push_back(mk(0, 0,      0,            0, 32'h20,    0,            3'b010, 1, 32'd7,        32'hEE34_5678));
        vq.push_back(mk(0, 0,      0,            1, 32'h20,    32'd9,        3'b010, 1, 32'd7,        32'hEE34_5678));
        vq.push_back(mk(0, 0,      0,            0, 32'h20,    0,            3'b010, 1, 32'd9,        32'hEE34_5678));
        vq.push_back(mk(0, 0,      0,            1, 32'h408,   32'd55,       3'b010, 0, 0,            32'hEE34_5678));
        vq.push_back(mk(0, 0,      0,            0, 8,         0,            3'b010, 1, 32'd55,       32'hEE34_5678));

        foreach (vq[i]) step(vq[i], i);

        // Mid-cycle async reset clears outputs at once.
        #2;
        rst = 1'b1;
        #1;
        check("async rst rd_data", rd_data, 32'h0);
        check("async rst outport", outport, 32'h0);

        // Stores during reset must be ignored (RAM and outport).
        wren = 1'b1; addr = 0; wr_data = 32'h2222_2222; funct3 = WORD;
        @(posedge clk); #1;
        addr = 32'hFFFC;
        @(posedge clk); #1;
        check("store in rst outport", outport, 32'h0);
        wren = 1'b0;
        rst  = 1'b0;

        step(mk(0, 0, 0, 0, 0,      0, 3'b010, 1, 32'hCAFE_F00D, 0), 200);
        step(mk(0, 0, 0, 0, 32'h20, 0, 3'b010, 1, 32'd9,         0), 201);
        step(mk(0, 0, 0, 0, 32'hFFFC, 0, 3'b010, 1, 32'h0,       0), 202);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory.md
Name: memory

Overview:
- Byte-addressed, word-organised data memory for the RISC-V core.
- Executes loads and stores in byte, halfword and word sizes, selected by the RISC-V load/store funct3 code.
- Provides a side "flash" write port so a testbench or loader can preload words, including while the core is held in reset.
- Provides one memory-mapped output register, `outport`.

Parameters:
- WIDTH, 32, data and address width in bits.
- DEPTH, 256, number of WIDTH-bit words of storage; must be a power of two.
- OUTPORT_ADDR, 32'h0000_FFFC, byte address of the memory-mapped output register.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr  in  WIDTH  byte address for core load/store.
- wren  in  1  0 = read, 1 = write (store).
- wr_data  in  WIDTH  store data; the low bytes are used for byte and halfword stores.
- funct3  in  funct3_t  access size and signedness.
- rd_data  out  WIDTH  registered load result.
- outport  out  WIDTH  memory-mapped output register.
- flash_en  in  1  flash write strobe.
- flash_addr  in  WIDTH  byte address of the flash write.
- flash_data  in  WIDTH  full word written by flash.

Behaviour:
- Reset (async, rst=1):
  - rd_data and outport clear to 0 immediately.
  - RAM contents are NOT cleared.
  - Core stores (wren) are ignored while rst=1.
  - Flash writes remain active while rst=1.
- Addressing:
  - Word index = addr[log2(DEPTH)+1:2]; upper address bits are ignored, so addresses alias/wrap.
  - Byte lane = addr[1:0]; ordering is little-endian.
- Flash: on a rising edge with flash_en=1, write the full flash_data into word flash_addr[log2(DEPTH)+1:2]. flash_addr[1:0] is ignored.
- Priority: if flash_en and wren are asserted in the same cycle, the flash write wins and the core store is dropped.
- Store (wren=1, rst=0, flash_en=0), on the rising edge:
  - BYTE (3'b000): write wr_data[7:0] to lane addr[1:0].
  - HALF (3'b001): write wr_data[15:0] to lanes {addr[1],0} and {addr[1],1}; addr[0] is ignored.
  - WORD (3'b010): write all 4 lanes; addr[1:0] is ignored.
  - Other funct3 codes: no write.
- Store to OUTPORT_ADDR (word-aligned compare on addr[WIDTH-1:2]):
  - Updates outport with the same lane rules applied to the current outport value.
  - RAM is not written.
- Load:
  - Synchronous read: rd_data updates on the rising edge after addr/funct3 are presented; latency 1 cycle.
  - rd_data updates every cycle, including cycles with wren=1. A write returns the old data (read-before-write).
  - BYTE (000): selected byte, sign-extended.
  - HALF (001): selected half, sign-extended.
  - WORD (010): full word.
  - BYTE_U (100): selected byte, zero-extended.
  - HALF_U (101): selected half, zero-extended.
  - Other codes: full word.
  - A load from OUTPORT_ADDR returns outport, with the same extraction rules.
- outport holds its value until the next store to OUTPORT_ADDR or a reset.

Decomposition:
- Shared package LOAD_STORE_FNS:
  - Enum funct3_t (3 bits): BYTE=0, HALF=1, WORD=2, BYTE_U=4, HALF_U=5.
- Sub-module byte_en_ram:
  - DEPTH x 32, with 4-bit byte-enable write and registered read.
  - The flash path and the store path are muxed into its single write port.
- The top level contains the lane/enable generation, load extraction and sign extension, the outport decode, and the outport register.

Test Plan:
- Flash during reset: with rst=1, flash 0->12345, 4->678910, 12->32'hDEADBEEF; release rst; WORD reads of 0, 4, 12 give rd_data 12345, 678910, 32'hDEADBEEF one cycle after each addr is applied.
- Word store: addr=8, wr_data=101010, wren=1 for one cycle, then a WORD read of 8 gives 101010. Words at 4 and 12 are unchanged.
- Byte/half store and load:
  - Flash 16->0; store BYTE 0x80 at 17.
  - WORD read of 16 = 32'h0000_8000.
  - BYTE read of 17 = 32'hFFFF_FF80; BYTE_U read of 17 = 32'h0000_0080.
  - Store HALF 0xBEEF at 18, then HALF_U read of 18 = 32'h0000_BEEF and HALF read of 18 = 32'hFFFF_BEEF.
- Outport: WORD store 32'h1234_5678 to OUTPORT_ADDR sets outport to 32'h1234_5678 after the edge. RAM word OUTPORT_ADDR mod DEPTH is unchanged; a load from OUTPORT_ADDR returns 32'h1234_5678.
- Priority and reset:
  - flash_en and wren together at address 0: the flash data is stored.
  - Asserting rst mid-run clears rd_data and outport asynchronously, and RAM contents survive (a read after release returns the prior data).
  - A wren store issued during rst has no effect.
